instruction_loader: RTL and testbench



---
 rtl/instruction_loader_pkg.sv | 35 +++
 rtl/instruction_fifo.sv | 56 +++++
 rtl/instruction_loader.sv | 121 ++++++++++++
 tb/tb_instruction_loader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared constants for the byte-serial instruction loader: word geometry, NOP, cpu opcodes, byte lanes.
package instruction_loader_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned BYTE_W  = 8;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_00FF;

  // cpu opcode encoding; the loader passes all of them through untouched
  localparam logic [BYTE_W-1:0] OP_ADD      = 8'h00;
  localparam logic [BYTE_W-1:0] OP_SUB      = 8'h01;
  localparam logic [BYTE_W-1:0] OP_AND      = 8'h02;
  localparam logic [BYTE_W-1:0] OP_OR       = 8'h03;
  localparam logic [BYTE_W-1:0] OP_XOR      = 8'h04;
  localparam logic [BYTE_W-1:0] OP_SHL      = 8'h06;
  localparam logic [BYTE_W-1:0] OP_SHR      = 8'h07;
  localparam logic [BYTE_W-1:0] OP_LDI      = 8'h09;
  localparam logic [BYTE_W-1:0] OP_MOV      = 8'h0A;
  localparam logic [BYTE_W-1:0] OP_CMP      = 8'h0B;
  localparam logic [BYTE_W-1:0] OP_RF_RESET = 8'h0C;
  localparam logic [BYTE_W-1:0] OP_HALT     = 8'h0D;
  localparam logic [BYTE_W-1:0] OP_NOP      = 8'hFF;

  // Byte-lane index within a word (big-endian arrival order 3,2,1,0)
  localparam int unsigned LANE_WADDR  = 3;
  localparam int unsigned LANE_RADDR1 = 2;
  localparam int unsigned LANE_RADDR2 = 1;
  localparam int unsigned LANE_OPCODE = 0;

  function automatic logic [BYTE_W-1:0] word_parity(input logic [INSTR_W-1:0] w);
    return w[LANE_WADDR*BYTE_W +: BYTE_W] ^ w[LANE_RADDR1*BYTE_W +: BYTE_W] ^
           w[LANE_RADDR2*BYTE_W +: BYTE_W] ^ w[LANE_OPCODE*BYTE_W +: BYTE_W];
  endfunction

endpackage

// File: rtl/instruction_fifo.sv
// Synchronous power-of-two FIFO with flush; head word is visible on o_data whenever non-empty.
module instruction_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full && !i_flush;
  assign w_pop_ok  = i_pop && !o_empty && !i_flush;
  assign o_data    = r_mem[r_rptr];
  assign o_count   = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + PTR_W'(1);
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + CNT_W'(1);
      else if (w_pop_ok && !w_push_ok) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Assembles big-endian bytes into instruction words, buffers them and issues one per enabled cycle.
// Define INSTRUCTION_LOADER_PARITY_EN for 5-byte words whose last byte is the XOR of the first four.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clock_in,
  input  logic               reset_n_in,
  input  logic               flush_in,
  input  logic [BYTE_W-1:0]  byte_in,
  input  logic               byte_valid_in,
  output logic               byte_ready_out,
  input  logic               issue_enable_in,
  output logic [INSTR_W-1:0] current_instruction_out,
  output logic               instruction_valid_out,
  output logic [CNT_W-1:0]   fifo_count_out,
  output logic               parity_error_out
);

`ifdef INSTRUCTION_LOADER_PARITY_EN
  localparam int unsigned LAST_BYTE = 4;
  localparam int unsigned BCNT_W    = 3;
`else
  localparam int unsigned LAST_BYTE = 3;
  localparam int unsigned BCNT_W    = 2;
`endif

  logic [BCNT_W-1:0]  r_byte_cnt;
  logic [23:0]        r_hi;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;
  logic [INSTR_W-1:0] w_word;
  logic [INSTR_W-1:0] w_head;
  logic               w_last;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;

  assign w_last         = (r_byte_cnt == BCNT_W'(LAST_BYTE));
  assign byte_ready_out = !flush_in && (!w_last || !w_full);
  assign w_accept       = byte_valid_in && byte_ready_out;
  assign w_pop          = issue_enable_in && !w_empty && !flush_in;

  // Byte counter and storage for the first three lanes
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_byte_cnt <= '0;
      r_hi       <= '0;
    end else if (flush_in) begin
      r_byte_cnt <= '0;
    end else if (w_accept) begin
      case (r_byte_cnt)
        BCNT_W'(0): r_hi[23:16] <= byte_in;
        BCNT_W'(1): r_hi[15:8]  <= byte_in;
        BCNT_W'(2): r_hi[7:0]   <= byte_in;
        default: ;
      endcase
      r_byte_cnt <= w_last ? '0 : r_byte_cnt + BCNT_W'(1);
    end
  end

`ifdef INSTRUCTION_LOADER_PARITY_EN
  logic [BYTE_W-1:0] r_opc;
  logic              r_par_err;
  logic              w_par_ok;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_opc     <= '0;
      r_par_err <= 1'b0;
    end else begin
      if (w_accept && (r_byte_cnt == BCNT_W'(3))) r_opc <= byte_in;
      r_par_err <= w_accept && w_last && !w_par_ok;
    end
  end

  assign w_word           = {r_hi, r_opc};
  assign w_par_ok         = (byte_in == word_parity(w_word));
  assign w_push           = w_accept && w_last && w_par_ok;
  assign parity_error_out = r_par_err;
`else
  assign w_word           = {r_hi, byte_in};
  assign w_push           = w_accept && w_last;
  assign parity_error_out = 1'b0;
`endif

  instruction_fifo #(
    .DATA_W (INSTR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clock_in),
    .i_rst_n (reset_n_in),
    .i_flush (flush_in),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (fifo_count_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Output register: popped head word, otherwise NOP
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else begin
      r_instr <= w_pop ? w_head : NOP_INSTR;
      r_valid <= w_pop;
    end
  end

  assign current_instruction_out = r_instr;
  assign instruction_valid_out   = r_valid;

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized and directed bench for instruction_loader against a queue-based reference model.
// Honors INSTRUCTION_LOADER_PARITY_EN the same way as the design.
module tb_instruction_loader;

  localparam int unsigned DEPTH = 4;
`ifdef INSTRUCTION_LOADER_PARITY_EN
  localparam int unsigned BYTES = 5;
`else
  localparam int unsigned BYTES = 4;
`endif
  localparam logic [31:0] NOP = 32'h0000_00FF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  bdat = 8'h00;
  logic        bval = 1'b0;
  logic        rdy;
  logic        en = 1'b0;
  logic [31:0] instr;
  logic        ivalid;
  logic [2:0]  cnt;
  logic        perr;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0]  m_pend[$];
  logic [31:0] m_q[$];
  logic [31:0] m_out   = NOP;
  logic        m_valid = 1'b0;
  logic        m_perr  = 1'b0;

  always #5 clk = ~clk;

  instruction_loader #(.FIFO_DEPTH(DEPTH)) dut (
    .clock_in                (clk),
    .reset_n_in              (rst_n),
    .flush_in                (flush),
    .byte_in                 (bdat),
    .byte_valid_in           (bval),
    .byte_ready_out          (rdy),
    .issue_enable_in         (en),
    .current_instruction_out (instr),
    .instruction_valid_out   (ivalid),
    .fifo_count_out          (cnt),
    .parity_error_out        (perr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend.delete();
    m_q.delete();
    m_out   = NOP;
    m_valid = 1'b0;
    m_perr  = 1'b0;
  endtask

  // One clock: drive at negedge, check ready, clock, advance model, check registered outputs
  task automatic step(input logic f, input logic v, input logic [7:0] b, input logic e);
    logic        exp_rdy;
    logic        acc;
    logic [31:0] w;
    @(negedge clk);
    flush = f; bval = v; bdat = b; en = e;
    #1;
    exp_rdy = !f && ((m_pend.size() != BYTES - 1) || (m_q.size() < DEPTH));
    check("ready", 32'(rdy), 32'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    #1;
    m_perr = 1'b0;
    if (f) begin
      model_reset();
    end else begin
      if (e && m_q.size() > 0) begin
        m_out   = m_q.pop_front();
        m_valid = 1'b1;
      end else begin
        m_out   = NOP;
        m_valid = 1'b0;
      end
      if (acc) begin
        m_pend.push_back(b);
        if (m_pend.size() == BYTES) begin
          w = {m_pend[0], m_pend[1], m_pend[2], m_pend[3]};
`ifdef INSTRUCTION_LOADER_PARITY_EN
          if (m_pend[4] == (m_pend[0] ^ m_pend[1] ^ m_pend[2] ^ m_pend[3])) m_q.push_back(w);
          else m_perr = 1'b1;
`else
          m_q.push_back(w);
`endif
          m_pend.delete();
        end
      end
    end
    check("instr", instr, m_out);
    check("ivalid", 32'(ivalid), 32'(m_valid));
    check("count", 32'(cnt), 32'(m_q.size()));
    check("perr", 32'(perr), 32'(m_perr));
  endtask

  function automatic logic [7:0] lane(input logic [31:0] w, input int k);
    return w[(3 - k) * 8 +: 8];
  endfunction

  task automatic send_bytes(input logic [31:0] w, input int nb, input logic e);
    for (int k = 0; k < nb; k++) begin
      if (k < 4) step(1'b0, 1'b1, lane(w, k), e);
      else       step(1'b0, 1'b1, lane(w, 0) ^ lane(w, 1) ^ lane(w, 2) ^ lane(w, 3), e);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr"}, instr, NOP);
    check({tag, "_valid"}, 32'(ivalid), 32'd0);
    check({tag, "_count"}, 32'(cnt), 32'd0);
    check({tag, "_ready"}, 32'(rdy), 32'd1);
    check({tag, "_perr"}, 32'(perr), 32'd0);
  endtask

  initial begin
    logic [31:0] words [5];
    logic        phase_en;
    logic [7:0]  rb;
    words[0] = 32'h1122_3300; words[1] = 32'h4455_6601; words[2] = 32'h7788_990C;
    words[3] = 32'hAABB_CC0D; words[4] = 32'hDEAD_BE04;

    // Reset values
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Single word, then NOP
    send_bytes(32'h0102_0300, BYTES, 1'b1);
    check("single_count", 32'(cnt), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("single_word", instr, 32'h0102_0300);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("single_nop", instr, NOP);

    // Fill FIFO, stall the fifth word's last byte, then drain in order
    for (int i = 0; i < 4; i++) send_bytes(words[i], BYTES, 1'b0);
    check("full_count", 32'(cnt), 32'd4);
    send_bytes(words[4], BYTES - 1, 1'b0);
    step(1'b0, 1'b1, (BYTES == 5) ? (8'hDE ^ 8'hAD ^ 8'hBE ^ 8'h04) : 8'h04, 1'b0);
    check("stall_ready", 32'(rdy), 32'd0);
    for (int i = 0; i < 6; i++)
      step(1'b0, i < 2, (BYTES == 5) ? (8'hDE ^ 8'hAD ^ 8'hBE ^ 8'h04) : 8'h04, 1'b1);
    check("drain_empty", 32'(cnt), 32'd0);

    // Flush discards a partial word
    send_bytes(32'h5566_7788, 2, 1'b1);
    step(1'b1, 1'b1, 8'h99, 1'b1);
    send_bytes(32'h0A0B_0509, BYTES, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("flush_word", instr, 32'h0A0B_0509);

`ifdef INSTRUCTION_LOADER_PARITY_EN
    // Bad parity drops the word; good parity issues it
    send_bytes(32'h0102_0300, 4, 1'b1);
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    check("par_err_pulse", 32'(perr), 32'd1);
    check("par_err_count", 32'(cnt), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("par_err_clear", 32'(perr), 32'd0);
    send_bytes(32'h0102_0400, 4, 1'b1);
    step(1'b0, 1'b1, 8'h07, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("par_ok_word", instr, 32'h0102_0400);
`endif

    // Asynchronous reset with words buffered and one issuing
    for (int i = 0; i < 3; i++) send_bytes(words[i], BYTES, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("pre_rst_valid", 32'(ivalid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

    // Randomized traffic
    phase_en = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0) phase_en = ($urandom_range(0, 1) == 1);
      rb = 8'($urandom());
`ifdef INSTRUCTION_LOADER_PARITY_EN
      if (m_pend.size() == 4 && $urandom_range(0, 4) != 0)
        rb = m_pend[0] ^ m_pend[1] ^ m_pend[2] ^ m_pend[3];
`endif
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7, rb,
           phase_en ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
